pcs_sidestream_scrambler_gen: RTL
=================================

Name: pcs_sidestream_scrambler_gen

Overview:
Parametrised 1000BASE-T side-stream scrambler generator. It produces LANES scrambler bits per beat from a Galois-free (Fibonacci) LFSR with runtime master/slave polynomial select. Each beat carries a free-running symbol index, and a one-entry valid/ready output register feeds the symbol encoder. It also captures the symbol index n0 at the start of each transmission, replacing the fixed 1-bit-per-cycle scrambler and the externally driven io_n/io_n0 inside the encoder.

Parameters:
- LFSR_W, 33: LFSR length; polynomial 1 + x^TAP + x^LFSR_W.
- TAP_MASTER, 13: middle tap used when io_slave=0.
- TAP_SLAVE, 20: middle tap used when io_slave=1.
- LANES, 1: LFSR steps per beat; legal range 1..8.
- CNT_W, 32: width of the symbol index counter.
- SEED, 1: default LFSR state; must be nonzero.

Ports:
- clock, in, 1: single clock; all state on rising edge.
- reset, in, 1: asynchronous, active-high.
- io_slave, in, 1: polynomial select (0 = master, 1 = slave); sampled on each advancing beat.
- io_seed_load, in, 1: load io_seed and restart.
- io_seed, in, LFSR_W: seed value.
- io_enable, in, 1: request to advance one beat.
- io_tx_enable, in, 1: MAC tx_enable, used only for n0 capture.
- io_out_ready, in, 1: downstream ready.
- io_out_valid, out, 1: output beat valid.
- io_out_bits, out, LANES: scrambler bits of the beat; bit k = new bit of step k, bit 0 oldest.
- io_out_state, out, LFSR_W: LFSR state after the beat (scr[0] newest).
- io_out_n, out, CNT_W: symbol index of the beat.
- io_n0, out, CNT_W: captured index.
- io_n0_valid, out, 1: io_n0 holds a captured value.

Behaviour:
- LFSR step: nb = scr[LFSR_W-1] ^ scr[TAP-1]; then scr <= {scr[LFSR_W-2:0], nb}. TAP is chosen by io_slave.
- Beat: LANES chained steps in one cycle (combinational unroll). The same TAP applies to all steps of the beat.
- Advance condition: adv = io_enable && (!io_out_valid || io_out_ready) && !io_seed_load.
- On adv:
  - LFSR takes the post-beat state.
  - Output register loads bits, state and the current cnt.
  - cnt <= cnt + 1.
  - io_out_valid <= 1.
- On io_out_ready && io_out_valid && !adv: io_out_valid <= 0.
- While valid && !ready: the output register holds stable, the LFSR and cnt freeze, and the io_enable request is ignored (not queued).
- Latency: 1 cycle from an accepted io_enable to io_out_valid. Throughput: 1 beat/cycle with ready held high.
- cnt wraps modulo 2^CNT_W. The first beat after reset or seed load carries io_out_n = 0.
- Seed load has priority over everything except reset:
  - scr <= (io_seed == 0) ? SEED : io_seed (lock-up protection).
  - cnt <= 0; io_out_valid <= 0; io_n0_valid <= 0.
  - The beat in flight is dropped.
- n0 capture:
  - A rising edge of io_tx_enable (registered previous value) with io_n0_valid = 0 sets io_n0 <= cnt and io_n0_valid <= 1.
  - Later rising edges are ignored until the next reset or seed load.
  - If the edge coincides with adv, the pre-increment cnt is captured.
- Mode change mid-stream: legal. It takes effect on the next advancing beat; the state is not reset.
- Reset values: scr = SEED, cnt = 0, io_out_valid = 0, io_out_bits = 0, io_out_state = SEED, io_out_n = 0, io_n0 = 0, io_n0_valid = 0, tx_enable history = 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first beat after deassert is index 0 with SEED.
- Elaboration check: TAP_MASTER and TAP_SLAVE lie in [1, LFSR_W-1], SEED != 0, 1 <= LANES <= 8.

Test Plan:
- Defaults, LANES=1, io_slave=0, ready=1, io_enable=1 after reset -> io_out_bits = 0 for beats n=0..11; bit = 1 at n=12; io_out_n increments 0,1,2,... each cycle.
- Same with io_slave=1 -> bits 0 for n=0..18, 1 at n=19.
- LANES=4, master -> beats n=0..2 give 4'b0000, n=3 gives 4'b0001. The full 1000-beat stream matches the LANES=1 golden stream regrouped 4 bits per beat.
- Backpressure: ready low for 3 cycles at n=5 -> io_out_n, io_out_bits and io_out_state stable for 3 cycles; the next accepted beat is n=6 with no bit skipped (compare against the golden stream).
- Seed load of 0 mid-run while valid=1 -> next cycle valid=0; next beat n=0 with state equal to SEED stepped once. Seed load of 33'h0AAAAAAAA -> the stream matches a software model from that seed.
- n0 / wrap: CNT_W=4, io_tx_enable rises at n=9 -> io_n0 = 9 and io_n0_valid = 1; a second rise is ignored; after n=15 the next beat is n=0. Async reset mid-beat -> all outputs are at reset values before the next edge.

Source files
------------

// File: rtl/pcs_sidestream_scrambler_gen.sv
// pcs_sidestream_scrambler_gen: multi-lane 1000BASE-T side-stream scrambler with a
// one-entry valid/ready output register, symbol index counter and n0 capture.
module pcs_sidestream_scrambler_gen #(
    parameter int                LFSR_W     = 33,
    parameter int                TAP_MASTER = 13,
    parameter int                TAP_SLAVE  = 20,
    parameter int                LANES      = 1,
    parameter int                CNT_W      = 32,
    parameter logic [LFSR_W-1:0] SEED       = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_slave,
    input  logic              io_seed_load,
    input  logic [LFSR_W-1:0] io_seed,
    input  logic              io_enable,
    input  logic              io_tx_enable,
    input  logic              io_out_ready,
    output logic              io_out_valid,
    output logic [LANES-1:0]  io_out_bits,
    output logic [LFSR_W-1:0] io_out_state,
    output logic [CNT_W-1:0]  io_out_n,
    output logic [CNT_W-1:0]  io_n0,
    output logic              io_n0_valid
);
    if (TAP_MASTER < 1 || TAP_MASTER > LFSR_W - 1 || TAP_SLAVE < 1 || TAP_SLAVE > LFSR_W - 1 ||
        SEED == '0 || LANES < 1 || LANES > 8) begin : g_param_check
        $error("pcs_sidestream_scrambler_gen: illegal parameter set");
    end

    logic [LFSR_W-1:0] scr_q, scr_d, scr_nxt, out_state_q, out_state_d;
    logic [LANES-1:0]  bits_nxt, out_bits_q, out_bits_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, out_n_q, out_n_d, n0_q, n0_d;
    logic              out_valid_q, out_valid_d, n0_valid_q, n0_valid_d, tx_prev_q, tx_prev_d;
    logic              adv, capture;

    // Unrolled beat: every step of the beat uses the same tap selection.
    always_comb begin
        scr_nxt  = scr_q;
        bits_nxt = '0;
        for (int k = 0; k < LANES; k++) begin
            bits_nxt[k] = scr_nxt[LFSR_W-1] ^ (io_slave ? scr_nxt[TAP_SLAVE-1] : scr_nxt[TAP_MASTER-1]);
            scr_nxt     = {scr_nxt[LFSR_W-2:0], bits_nxt[k]};
        end
    end

    always_comb begin
        adv         = io_enable && (!out_valid_q || io_out_ready) && !io_seed_load;
        capture     = io_tx_enable && !tx_prev_q && !n0_valid_q && !io_seed_load;
        scr_d       = io_seed_load ? ((io_seed == '0) ? SEED : io_seed) : (adv ? scr_nxt : scr_q);
        cnt_d       = io_seed_load ? '0 : (adv ? cnt_q + 1'b1 : cnt_q);
        out_valid_d = io_seed_load ? 1'b0 : (adv ? 1'b1 : (out_valid_q && !io_out_ready));
        out_bits_d  = adv ? bits_nxt : out_bits_q;
        out_state_d = adv ? scr_nxt : out_state_q;
        out_n_d     = adv ? cnt_q : out_n_q;
        n0_d        = capture ? cnt_q : n0_q;
        n0_valid_d  = io_seed_load ? 1'b0 : (capture || n0_valid_q);
        tx_prev_d   = io_tx_enable;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scr_q       <= SEED;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_state_q <= SEED;
            out_n_q     <= '0;
            n0_q        <= '0;
            n0_valid_q  <= 1'b0;
            tx_prev_q   <= 1'b0;
        end else begin
            scr_q       <= scr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_state_q <= out_state_d;
            out_n_q     <= out_n_d;
            n0_q        <= n0_d;
            n0_valid_q  <= n0_valid_d;
            tx_prev_q   <= tx_prev_d;
        end
    end

    assign io_out_valid = out_valid_q;
    assign io_out_bits  = out_bits_q;
    assign io_out_state = out_state_q;
    assign io_out_n     = out_n_q;
    assign io_n0        = n0_q;
    assign io_n0_valid  = n0_valid_q;
endmodule
